// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: one valid/ready word-bus transaction per access,
// store lane steering, load alignment and extension, and a pipeline stall until completion.
module load_store_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  StrobeM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        LoadValidM,
  output logic        StallM,
  output logic        MisalignM,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusWStrb,
  output logic        BusWrite,
  output logic        BusValid,
  input  logic        BusReady,
  input  logic [31:0] BusRData
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, next_state;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        legal, aligned, accept;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (MemWriteM)
      legal = (StrobeM == 3'b000) || (StrobeM == 3'b001) || (StrobeM == 3'b010);
    else
      legal = (StrobeM == 3'b000) || (StrobeM == 3'b001) || (StrobeM == 3'b010) ||
              (StrobeM == 3'b100) || (StrobeM == 3'b101);
    case (StrobeM[1:0])
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign accept = (state == IDLE) && MemReqM && legal && aligned;

  // Stall and misalign terms are gated by reset so both read 0 while RST is low.
  assign StallM     = RST && (accept || (state == REQ));
  assign MisalignM  = RST && (state == IDLE) && MemReqM && legal && !aligned;
  assign BusValid   = (state == REQ);
  assign LoadValidM = (state == DONE) && !BusWrite;

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = WriteDataM;
    case (StrobeM[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << ALUResultM[1:0];
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: begin
        wstrb_d = 4'b1111;
        wdata_d = WriteDataM;
      end
    endcase
    if (!MemWriteM)
      wstrb_d = 4'b0000;
  end

  always_comb begin
    byte_sel  = BusRData[7:0];
    half_sel  = offset_q[1] ? BusRData[31:16] : BusRData[15:0];
    load_data = BusRData;
    case (offset_q)
      2'b01:   byte_sel = BusRData[15:8];
      2'b10:   byte_sel = BusRData[23:16];
      2'b11:   byte_sel = BusRData[31:24];
      default: byte_sel = BusRData[7:0];
    endcase
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'b0, byte_sel};
      3'b101:  load_data = {16'b0, half_sel};
      default: load_data = BusRData;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = REQ;
      REQ:     if (BusReady) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      BusAddr   <= 32'b0;
      BusWData  <= 32'b0;
      BusWStrb  <= 4'b0;
      BusWrite  <= 1'b0;
      funct3_q  <= 3'b0;
      offset_q  <= 2'b0;
      ReadDataM <= 32'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        BusAddr  <= {ALUResultM[31:2], 2'b00};
        BusWData <= wdata_d;
        BusWStrb <= wstrb_d;
        BusWrite <= MemWriteM;
        funct3_q <= StrobeM;
        offset_q <= ALUResultM[1:0];
      end
      // ReadDataM only changes when a load completes; stores leave it untouched.
      if ((state == REQ) && BusReady && !BusWrite)
        ReadDataM <= load_data;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I pipeline. It takes the memory-stage request (address from the ALU, store data, MemWrite, 3-bit funct3 strobe) and runs a single valid/ready transaction on the word-wide data bus. It generates byte-lane strobes and replicated write data for stores, and aligns plus sign- or zero-extends read data for loads. It holds the pipeline with a stall until the bus completes.

## Interface
Parameters:
- none; address and data are fixed at 32 bits, with 4 byte lanes.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- MemReqM  in  1  memory-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load; qualified by MemReqM.
- StrobeM  in  3  funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  rs2 store value.
- ReadDataM  out  32  aligned, extended load result.
- LoadValidM  out  1  ReadDataM valid this cycle.
- StallM  out  1  freeze PC/IF/ID/EX/M registers.
- MisalignM  out  1  1-cycle flag for a misaligned access.
- BusAddr  out  32  word address, {ALUResultM[31:2], 2'b00}.
- BusWData  out  32  lane-replicated write data.
- BusWStrb  out  4  byte enables; all 0 for loads.
- BusWrite  out  1  1 = write transaction.
- BusValid  out  1  request valid.
- BusReady  in  1  slave accept/complete.
- BusRData  in  32  read data; valid when BusReady is high and BusWrite is 0.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, MemReqM=1, legal and aligned:
  - latch BusAddr, BusWData, BusWStrb, BusWrite, funct3 and offset = ALUResultM[1:0];
  - assert StallM combinationally this cycle;
  - go to REQ.
- REQ:
  - BusValid=1; bus outputs stay stable; StallM=1.
  - On BusReady=1 at a rising edge: for loads, register the extended data into ReadDataM; go to DONE.
  - BusValid is never withdrawn before BusReady.
- DONE:
  - StallM=0, so the pipeline advances; LoadValidM=1 for loads only.
  - MemReqM is ignored here; it is still the same instruction.
  - Go to IDLE.
- Alignment rules:
  - LH, LHU and SH need ALUResultM[0]=0.
  - LW and SW need ALUResultM[1:0]=00.
  - Byte accesses are always aligned.
- Misaligned access: no bus transaction, no stall, MisalignM=1 for that IDLE cycle, LoadValidM=0, state stays IDLE.
- Illegal funct3 (loads 011, 110, 111; stores other than 000/001/010): no-op. No bus transaction, no stall, MisalignM=0.
- Store lanes:
  - SB: WStrb = 0001 << off; WData = {4{rs2[7:0]}}.
  - SH: WStrb = 0011 << off; WData = {2{rs2[15:0]}}.
  - SW: WStrb = 1111; WData = rs2.
- Load extract:
  - byte = BusRData[8*off +: 8]; half = BusRData[8*off +: 16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- ReadDataM holds its last value until the next load completes.

## Timing
- Reset (RST low, async): state=IDLE. BusValid, BusWrite, BusWStrb, StallM, LoadValidM and MisalignM are 0. BusAddr, BusWData and ReadDataM are 0.
- Reset mid-transaction: abandoned immediately, with BusValid dropping asynchronously. The slave must tolerate this.
- Minimum latency, from the request cycle (c0) to the advance cycle (DONE):
  - c0: IDLE, StallM=1.
  - c1: REQ, BusValid=1, BusReady=1.
  - c2: DONE, StallM=0, LoadValidM=1.
  - Total: 2 stall cycles.
- Each BusReady-low cycle in REQ adds exactly one stall cycle.
- Back-to-back memory ops: the second request is sampled in the IDLE cycle after DONE. A one-cycle bubble is inherent.
- StallM = (IDLE & MemReqM & legal & aligned) | REQ. It is combinational from the M-stage inputs.
- BusReady while not in REQ is ignored.

## Test plan
- SW, addr 0x100, rs2 0xDEADBEEF, BusReady high in the first REQ cycle -> BusAddr 0x100, WStrb 1111, WData 0xDEADBEEF, BusWrite 1; StallM high for 2 cycles; LoadValidM stays 0.
- SB, addr 0x203, rs2 0x000000A5 -> BusAddr 0x200, WStrb 1000, WData 0xA5A5A5A5. SH, addr 0x202, rs2 0x1234 -> WStrb 1100, WData 0x12341234.
- BusRData 0x80F07F01:
  - LB at off 3 -> 0xFFFFFF80.
  - LBU at off 3 -> 0x00000080.
  - LH at off 2 -> 0xFFFF80F0.
  - LHU at off 0 -> 0x00007F01.
  - LW -> 0x80F07F01.
  - LoadValidM high for exactly 1 cycle each.
- LW, BusReady held low for 3 REQ cycles -> BusValid and bus fields stable throughout; StallM high for 5 cycles; the next load issues only after the DONE cycle.
- LW at 0x102 and SH at 0x101 -> MisalignM pulse for 1 cycle, BusValid never high, StallM 0. Illegal load funct3 011 -> no bus activity, MisalignM 0.
- RST pulled low while in REQ -> BusValid and StallM go to 0 asynchronously. After release, a fresh LW completes normally with a 2-cycle stall.
